// File: rtl/ahb_app_arbiter_if.sv
// Requester-side and master-side signal bundle for ahb_app_arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface ahb_app_arbiter_if;
    logic [1:0]  req;
    logic [7:0]  req_opcode;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_beats;
    logic [1:0]  gnt;
    logic [1:0]  wready;
    logic [31:0] rdata;
    logic [1:0]  rvalid;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [3:0]  opcode;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        enable;
    logic        new_trans;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;
    logic        error;
    logic        WAIT;

    modport slave (
        input  req, req_opcode, req_addr, req_wdata, req_beats,
        input  data_out, data_valid, error, WAIT,
        output gnt, wready, rdata, rvalid, done, err,
        output opcode, addr, data_in, enable, new_trans, busy
    );

    modport master (
        output req, req_opcode, req_addr, req_wdata, req_beats,
        output data_out, data_valid, error, WAIT,
        input  gnt, wready, rdata, rvalid, done, err,
        input  opcode, addr, data_in, enable, new_trans, busy
    );
endinterface

// File: rtl/ahb_app_arbiter.sv
// Two-requester arbiter in front of a single bus master: issues a transaction,
// walks its burst addresses, drains, and aborts on error or a stuck WAIT.
module ahb_app_arbiter (
    input  logic             HCLK,
    input  logic             HRESETn,
    ahb_app_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BURST = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  gnt_r;
    logic [1:0]  err_r;
    logic        last_gnt_r;
    logic        enable_r;
    logic        new_trans_r;
    logic [3:0]  opcode_r;
    logic [2:0]  cur_op_r;
    logic [31:0] cur_addr_r;
    logic [3:0]  beat_cnt_r;
    logic [7:0]  wd_r;

    logic        win_s;
    logic [3:0]  sel_op_s;
    logic [31:0] sel_addr_s;
    logic [3:0]  sel_beats_s;
    logic        active_s;
    logic        abort_s;
    logic        accept_s;

    function automatic logic [31:0] size_inc(input logic [1:0] size);
        case (size)
            2'b01:   size_inc = 32'd2;
            2'b10:   size_inc = 32'd4;
            default: size_inc = 32'd1;
        endcase
    endfunction

    // Pick the winner (tie goes to the requester not served last) and its fields.
    always_comb begin
        if (bus.req == 2'b11) begin
            win_s = ~last_gnt_r;
        end else if (bus.req[1]) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        sel_op_s    = win_s ? bus.req_opcode[7:4]    : bus.req_opcode[3:0];
        sel_addr_s  = win_s ? bus.req_addr[63:32]    : bus.req_addr[31:0];
        sel_beats_s = win_s ? bus.req_beats[7:4]     : bus.req_beats[3:0];
    end

    assign active_s = (state_r == ST_ISSUE) || (state_r == ST_BURST) || (state_r == ST_DRAIN);
    // The 255th consecutive WAIT cycle counts as an error.
    assign abort_s  = active_s && (bus.error || (bus.WAIT && (wd_r == 8'd254)));
    assign accept_s = active_s && !bus.WAIT && !bus.error;

    assign bus.gnt       = gnt_r;
    assign bus.err       = err_r;
    assign bus.enable    = enable_r;
    assign bus.new_trans = new_trans_r;
    assign bus.opcode    = opcode_r;
    assign bus.addr      = cur_addr_r;
    assign bus.busy      = 1'b0;
    assign bus.rdata     = bus.data_out;
    assign bus.rvalid    = bus.data_valid ? gnt_r : 2'b00;
    assign bus.data_in   = gnt_r[1] ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
    assign bus.wready    = (accept_s && (state_r != ST_DRAIN) && cur_op_r[2]) ? gnt_r : 2'b00;
    assign bus.done      = (accept_s && (state_r == ST_DRAIN)) ? gnt_r : 2'b00;

    // Transaction FSM with registered bus-side outputs.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            last_gnt_r  <= 1'b1;
            gnt_r       <= 2'b00;
            err_r       <= 2'b00;
            enable_r    <= 1'b0;
            new_trans_r <= 1'b0;
            opcode_r    <= 4'd0;
            cur_op_r    <= 3'd0;
            cur_addr_r  <= 32'd0;
            beat_cnt_r  <= 4'd0;
            wd_r        <= 8'd0;
        end else begin
            err_r <= 2'b00;
            if (abort_s) begin
                state_r     <= ST_ERR;
                err_r       <= gnt_r;
                enable_r    <= 1'b0;
                new_trans_r <= 1'b0;
                opcode_r    <= 4'd0;
                cur_addr_r  <= 32'd0;
                beat_cnt_r  <= 4'd0;
                wd_r        <= 8'd0;
            end else if (active_s && bus.WAIT) begin
                wd_r <= wd_r + 8'd1;
            end else begin
                wd_r <= 8'd0;
                case (state_r)
                    ST_IDLE: begin
                        if (bus.req != 2'b00) begin
                            state_r     <= ST_ISSUE;
                            gnt_r       <= win_s ? 2'b10 : 2'b01;
                            cur_op_r    <= sel_op_s[2:0];
                            opcode_r    <= sel_op_s;
                            cur_addr_r  <= sel_addr_s;
                            beat_cnt_r  <= sel_beats_s;
                            enable_r    <= 1'b1;
                            new_trans_r <= 1'b1;
                        end
                    end
                    ST_ISSUE, ST_BURST: begin
                        new_trans_r <= 1'b0;
                        if (beat_cnt_r == 4'd0) begin
                            state_r  <= ST_DRAIN;
                            opcode_r <= 4'd0;
                        end else begin
                            state_r    <= ST_BURST;
                            opcode_r   <= {1'b1, cur_op_r};
                            cur_addr_r <= cur_addr_r + size_inc(cur_op_r[1:0]);
                            beat_cnt_r <= beat_cnt_r - 4'd1;
                        end
                    end
                    ST_DRAIN: begin
                        state_r    <= ST_IDLE;
                        gnt_r      <= 2'b00;
                        enable_r   <= 1'b0;
                        cur_addr_r <= 32'd0;
                        last_gnt_r <= gnt_r[1];
                    end
                    ST_ERR: begin
                        state_r    <= ST_IDLE;
                        gnt_r      <= 2'b00;
                        last_gnt_r <= gnt_r[1];
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ahb_app_arbiter.sv
// Self-checking bench for ahb_app_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_ahb_app_arbiter;
    logic HCLK;
    logic HRESETn;
    int   n_chk;
    int   n_fail;

    ahb_app_arbiter_if bus ();

    ahb_app_arbiter dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: a queue of expected bus cycles built at grant time.
    typedef struct packed {
        logic        drain;
        logic        nt;
        logic [3:0]  op;
        logic [31:0] addr;
    } beat_t;

    beat_t exp_q[$];
    int    m_mode;   // 0 idle, 1 transferring, 2 error cycle
    int    m_owner;
    int    m_last;
    int    m_wcnt;
    logic  m_wr;

    int        grant_log[$];
    logic [1:0] prev_gnt;
    int        n_done_obs;
    int        n_err_obs;
    int        n_wr_obs;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode  = 0;
        m_last  = 1;
        m_wcnt  = 0;
        m_owner = 0;
        m_wr    = 1'b0;
    endtask

    task automatic check_cycle();
        logic [1:0]  eg;
        logic [1:0]  ew;
        logic [1:0]  ed;
        logic [1:0]  ee;
        logic [37:0] ectl;
        eg = 2'b00; ew = 2'b00; ed = 2'b00; ee = 2'b00; ectl = '0;
        if (m_mode == 1) begin
            eg   = (m_owner == 1) ? 2'b10 : 2'b01;
            ectl = {1'b1, exp_q[0].nt, exp_q[0].op, exp_q[0].addr};
            if (!bus.WAIT && !bus.error) begin
                if (exp_q[0].drain) ed = eg;
                else if (m_wr) ew = eg;
            end
        end else if (m_mode == 2) begin
            eg = (m_owner == 1) ? 2'b10 : 2'b01;
            ee = eg;
        end
        check_eq("gnt", 64'(bus.gnt), 64'(eg));
        check_eq("ctrl", 64'({bus.enable, bus.new_trans, bus.opcode, bus.addr}), 64'(ectl));
        check_eq("wready", 64'(bus.wready), 64'(ew));
        check_eq("done", 64'(bus.done), 64'(ed));
        check_eq("err", 64'(bus.err), 64'(ee));
        check_eq("rvalid", 64'(bus.rvalid), 64'(bus.data_valid ? eg : 2'b00));
        check_eq("rdata", 64'(bus.rdata), 64'(bus.data_out));
        check_eq("busy", 64'(bus.busy), 64'd0);
        if (m_mode != 0)
            check_eq("data_in", 64'(bus.data_in),
                     64'((m_owner == 1) ? bus.req_wdata[63:32] : bus.req_wdata[31:0]));
        if (bus.gnt != 2'b00 && prev_gnt == 2'b00) grant_log.push_back(int'(bus.gnt[1]));
        prev_gnt = bus.gnt;
        if (bus.done != 2'b00)   n_done_obs++;
        if (bus.err != 2'b00)    n_err_obs++;
        if (bus.wready != 2'b00) n_wr_obs++;
    endtask

    task automatic model_step();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] inc;
        int          b;
        if (!HRESETn) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: begin
                if (bus.req != 2'b00) begin
                    if (bus.req == 2'b11) m_owner = 1 - m_last;
                    else m_owner = bus.req[1] ? 1 : 0;
                    op  = bus.req_opcode[m_owner*4 +: 4];
                    a   = bus.req_addr[m_owner*32 +: 32];
                    b   = int'(bus.req_beats[m_owner*4 +: 4]);
                    inc = (op[1:0] == 2'b01) ? 32'd2 : ((op[1:0] == 2'b10) ? 32'd4 : 32'd1);
                    m_wr = op[2];
                    exp_q.delete();
                    for (int i = 0; i <= b; i++)
                        exp_q.push_back('{drain: 1'b0, nt: (i == 0),
                                          op: (i == 0) ? op : {1'b1, op[2:0]},
                                          addr: a + 32'(i) * inc});
                    exp_q.push_back('{drain: 1'b1, nt: 1'b0, op: 4'd0, addr: a + 32'(b) * inc});
                    m_mode = 1;
                    m_wcnt = 0;
                end
            end
            1: begin
                if (bus.error || (bus.WAIT && m_wcnt == 254)) begin
                    m_mode = 2;
                    m_wcnt = 0;
                end else if (bus.WAIT) begin
                    m_wcnt++;
                end else begin
                    m_wcnt = 0;
                    if (exp_q[0].drain) begin
                        m_last = m_owner;
                        m_mode = 0;
                    end
                    void'(exp_q.pop_front());
                end
            end
            2: begin
                m_last = m_owner;
                m_mode = 0;
            end
            default: m_mode = 0;
        endcase
    endtask

    task automatic run_cycle();
        bus.data_out   = $urandom;
        bus.data_valid = 1'($urandom_range(0, 1));
        bus.req_wdata  = {$urandom, $urandom};
        @(negedge HCLK);
        if (!HRESETn) model_reset();
        check_cycle();
        @(posedge HCLK);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic set_req(input logic [1:0] r, input logic [3:0] o0, input logic [3:0] o1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [3:0] b0, input logic [3:0] b1);
        bus.req        = r;
        bus.req_opcode = {o1, o0};
        bus.req_addr   = {a1, a0};
        bus.req_beats  = {b1, b0};
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        n_done_obs = 0; n_err_obs = 0; n_wr_obs = 0;
        prev_gnt = 2'b00;
        HRESETn = 1'b0;
        bus.WAIT = 1'b0; bus.error = 1'b0;
        set_req(2'b00, 4'd0, 4'd0, 32'd0, 32'd0, 4'd0, 4'd0);
        model_reset();
        run(3);
        HRESETn = 1'b1;

        // Single read beat from requester 0
        set_req(2'b01, 4'b0010, 4'b0000, 32'h100, 32'h0, 4'd0, 4'd0);
        n_done_obs = 0;
        run(1);
        bus.req = 2'b00;
        run(5);
        check_eq("single_done_cnt", 64'(n_done_obs), 64'd1);

        // Simultaneous requests after reset alternate starting with requester 0
        HRESETn = 1'b0;
        run(2);
        HRESETn = 1'b1;
        grant_log.delete();
        set_req(2'b11, 4'b0010, 4'b0010, 32'h10, 32'h20, 4'd0, 4'd0);
        run(16);
        check_eq("grant_cnt", 64'(grant_log.size() >= 4), 64'd1);
        if (grant_log.size() >= 4) begin
            check_eq("grant_0", 64'(grant_log[0]), 64'd0);
            check_eq("grant_1", 64'(grant_log[1]), 64'd1);
            check_eq("grant_2", 64'(grant_log[2]), 64'd0);
            check_eq("grant_3", 64'(grant_log[3]), 64'd1);
        end
        bus.req = 2'b00;
        run(4);

        // Write burst of four words from requester 1
        set_req(2'b10, 4'b0000, 4'b1110, 32'h0, 32'h200, 4'd0, 4'd3);
        n_wr_obs = 0; n_done_obs = 0;
        run(1);
        bus.req = 2'b00;
        run(8);
        check_eq("burst_wready_cnt", 64'(n_wr_obs), 64'd4);
        check_eq("burst_done_cnt", 64'(n_done_obs), 64'd1);

        // Same burst with a three-cycle stall in the middle
        set_req(2'b10, 4'b0000, 4'b1110, 32'h0, 32'h200, 4'd0, 4'd3);
        n_wr_obs = 0;
        run(1);
        bus.req = 2'b00;
        run(2);
        bus.WAIT = 1'b1;
        run(3);
        bus.WAIT = 1'b0;
        run(6);
        check_eq("stall_wready_cnt", 64'(n_wr_obs), 64'd4);

        // Error mid-burst, then the other requester is served
        grant_log.delete();
        n_err_obs = 0;
        set_req(2'b11, 4'b0010, 4'b0010, 32'h300, 32'h400, 4'd5, 4'd5);
        run(3);
        bus.error = 1'b1;
        run(1);
        bus.error = 1'b0;
        run(13);
        check_eq("error_err_cnt", 64'(n_err_obs), 64'd1);
        check_eq("error_log_cnt", 64'(grant_log.size() >= 2), 64'd1);
        if (grant_log.size() >= 2) begin
            check_eq("error_first", 64'(grant_log[0]), 64'd0);
            check_eq("error_next", 64'(grant_log[1]), 64'd1);
        end
        bus.req = 2'b00;
        run(20);

        // Watchdog expiry on a WAIT stuck high
        set_req(2'b01, 4'b0010, 4'b0000, 32'h500, 32'h0, 4'd2, 4'd0);
        n_err_obs = 0;
        run(1);
        bus.req = 2'b00;
        bus.WAIT = 1'b1;
        run(258);
        bus.WAIT = 1'b0;
        run(3);
        check_eq("watchdog_err_cnt", 64'(n_err_obs), 64'd1);

        // Byte burst wrapping past the top of the address space
        set_req(2'b01, 4'b1011, 4'b0000, 32'hFFFF_FFFF, 32'h0, 4'd2, 4'd0);
        run(1);
        bus.req = 2'b00;
        run(1);
        check_eq("wrap_addr", 64'(bus.addr), 64'd0);
        run(5);

        // Reset in the middle of a burst aborts silently
        set_req(2'b10, 4'b0000, 4'b1010, 32'h0, 32'h800, 4'd0, 4'd8);
        run(1);
        bus.req = 2'b00;
        run(3);
        n_done_obs = 0; n_err_obs = 0;
        HRESETn = 1'b0;
        run(2);
        check_eq("rst_done_cnt", 64'(n_done_obs), 64'd0);
        check_eq("rst_err_cnt", 64'(n_err_obs), 64'd0);
        HRESETn = 1'b1;
        run(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bus.req        = 2'($urandom_range(0, 3));
            bus.req_opcode = 8'($urandom);
            bus.req_addr   = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFF8, 32'hFFFF_FFFC} : {$urandom, $urandom};
            bus.req_beats  = 8'($urandom);
            bus.WAIT       = ($urandom_range(0, 3) == 0);
            bus.error      = ($urandom_range(0, 49) == 0);
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_app_arbiter.md
AHB_APP_ARBITER -- requirements
Module: ahb_app_arbiter

Interface
REQ-001 SHALL have port HCLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port HRESETn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port req, input, 2 bits: bit i set means requester i wants a transaction.
REQ-004 SHALL have port req_opcode, input, 8 bits: [4i+3:4i] is requester i opcode; bit3 incr, bit2 write, bits1:0 size.
REQ-005 SHALL have port req_addr, input, 64 bits: [32i+31:32i] is requester i start address.
REQ-006 SHALL have port req_wdata, input, 64 bits: [32i+31:32i] is requester i write data for the current beat.
REQ-007 SHALL have port req_beats, input, 8 bits: [4i+3:4i] is requester i beat count minus 1 (0 to 15).
REQ-008 SHALL have port gnt, output, 2 bits: one-hot owner of the master.
REQ-009 SHALL have port wready, output, 2 bits: pulse when the owner's write beat is accepted.
REQ-010 SHALL have port rdata, output, 32 bits: read data, shared by both requesters.
REQ-011 SHALL have port rvalid, output, 2 bits: rdata valid for requester i.
REQ-012 SHALL have port done, output, 2 bits: 1-cycle pulse when the owner's transaction completes.
REQ-013 SHALL have port err, output, 2 bits: 1-cycle pulse when the owner's transaction aborts.
REQ-014 SHALL have master-side outputs: opcode 4, addr 32, data_in 32, enable 1, new_trans 1, busy 1.
REQ-015 SHALL have master-side inputs: data_out 32, data_valid 1, error 1, WAIT 1.

Function
REQ-016 SHALL implement states IDLE, ISSUE, BURST, DRAIN and ERR.
REQ-017 In IDLE with any req bit set, SHALL grant one requester and go to ISSUE on the next edge.
REQ-018 On a tie, SHALL grant the requester not granted last (last_gnt register).
REQ-019 On grant, SHALL capture the winner's opcode, address and beat count into cur_op, cur_addr and beat_cnt; gnt SHALL be held from ISSUE until the cycle after done or err.
REQ-020 In ISSUE, SHALL drive enable=1, new_trans=1, opcode=cur_op and addr=cur_addr.
REQ-021 From ISSUE, SHALL go to DRAIN if beat_cnt=0, else to BURST.
REQ-022 In BURST, SHALL drive enable=1, new_trans=0 and opcode={1,cur_op[2:0]}.
REQ-023 In BURST, on each cycle with WAIT=0, SHALL increment addr by the size increment and decrement beat_cnt; when beat_cnt reaches 0, SHALL go to DRAIN.
REQ-024 Size increment SHALL be: size 00 = 1, 01 = 2, 10 = 4, 11 = 1 (byte). addr SHALL wrap modulo 2^32.
REQ-025 In DRAIN, SHALL drive enable=1, new_trans=0 and opcode=0000.
REQ-026 In DRAIN, on the first cycle with WAIT=0, SHALL pulse done[owner], update last_gnt and go to IDLE.
REQ-027 While WAIT=1 in any state, SHALL hold opcode, addr, data_in and beat_cnt, and SHALL pulse neither wready nor done.
REQ-028 data_in SHALL equal the owner's req_wdata.
REQ-029 For writes, wready[owner] SHALL pulse in each ISSUE or BURST cycle with WAIT=0.
REQ-030 rdata SHALL equal data_out; rvalid[owner] SHALL equal data_valid while gnt is nonzero, else rvalid SHALL be 0.
REQ-031 error=1 in ISSUE, BURST or DRAIN SHALL move to ERR and discard remaining beats.
REQ-032 In ERR (one cycle), SHALL drive enable=0, pulse err[owner], update last_gnt and go to IDLE.
REQ-033 An 8-bit watchdog SHALL count consecutive WAIT=1 cycles; at 255 it SHALL force ERR, exactly as an error does.
REQ-034 The watchdog SHALL clear whenever WAIT=0 or the state is IDLE.
REQ-035 Deasserting req during a transaction SHALL be ignored; the transfer SHALL complete.
REQ-036 No grant SHALL occur in the done or err cycle; at least one IDLE cycle SHALL separate transactions.
REQ-037 busy SHALL be tied 0.
REQ-038 In IDLE, enable, new_trans, opcode and addr SHALL be 0.

Reset
REQ-039 On HRESETn=0, SHALL force state IDLE and last_gnt=1.
REQ-040 On HRESETn=0, SHALL clear gnt, wready, rvalid, done, err, enable, new_trans, opcode, addr, beat_cnt and the watchdog.
REQ-041 Reset asserted mid-transaction SHALL abort it with no done or err pulse.

Verification
REQ-042 Single read, req=01, opcode0=0010, addr0=0x100, beats0=0 -> gnt=01, one ISSUE cycle with new_trans=1 and addr 0x100, rvalid=01 when data_valid, done=01, then IDLE.
REQ-043 Simultaneous req=11 after reset -> requester 0 granted first; with both still requesting, requester 1 next; grants then alternate.
REQ-044 Write burst, opcode1=1110, addr1=0x200, beats1=3 -> addr sequence 0x200, 0x204, 0x208, 0x20C, four wready pulses, done=10.
REQ-045 WAIT=1 for 3 cycles mid-burst -> addr and beat_cnt frozen, no wready pulses; resumes unchanged after WAIT falls.
REQ-046 error=1 in BURST -> ERR, err pulse on the owner, enable=0 for one cycle, remaining beats dropped, other requester then served.
REQ-047 WAIT held high 255 cycles -> err pulse; byte burst at addr 0xFFFFFFFF wraps to 0x00000000.
